regfile_scoreboard: RTL and testbench

Parametrised next-generation register file for the single-cycle and multi-cycle MIPS datapaths. It has NUM_RD read ports and two write ports: a primary result port and a link port that generalises JAL return-address writes. Same-cycle write-to-read bypass is provided. A per-register busy scoreboard tracks long-latency results (load, mult/div) and produces per-port busy flags and a stall request.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_busy_tracker.sv | 61 ++++++
 rtl/regfile_scoreboard.sv | 102 ++++++++++
 tb/tb_regfile_scoreboard.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the MIPS register file slice: well-known register
// indices, default geometry and the read-port limit.
package regfile_pkg;

    localparam int ZERO = 0;
    localparam int V0   = 2;
    localparam int A0   = 4;
    localparam int RA   = 31;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int MAX_NUM_RD     = 4;

endpackage

// File: rtl/regfile_busy_tracker.sv
// Per-register busy scoreboard for long-latency results (load, mult/div),
// with a sticky error flag for pending an already-busy register.
module regfile_busy_tracker
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr0_en,
    input  logic [ADDR_W-1:0]      wr0_addr,
    input  logic                   wr1_en,
    input  logic [ADDR_W-1:0]      wr1_addr,
    input  logic                   pend_en,
    input  logic [ADDR_W-1:0]      pend_addr,
    output logic [(2**ADDR_W)-1:0] busy,
    output logic                   pend_err
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] set_v, clr_v;
    logic                pend_err_q, pend_err_d;
    logic                wr0_eff, wr1_eff, pend_eff;

    assign wr0_eff  = wr0_en  && !(ZERO_REG && (wr0_addr  == '0));
    assign wr1_eff  = wr1_en  && !(ZERO_REG && (wr1_addr  == '0));
    assign pend_eff = pend_en && !(ZERO_REG && (pend_addr == '0));

    // A new pend on a register whose result is landing this cycle wins.
    always_comb begin
        set_v = '0;
        clr_v = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if ((wr0_eff && (wr0_addr == ADDR_W'(r))) ||
                (wr1_eff && (wr1_addr == ADDR_W'(r))))
                clr_v[r] = 1'b1;
            if (pend_eff && (pend_addr == ADDR_W'(r)))
                set_v[r] = 1'b1;
        end
        busy_d     = (busy_q & ~clr_v) | set_v;
        pend_err_d = pend_err_q |
                     (pend_eff && busy_q[pend_addr] && !clr_v[pend_addr]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            pend_err_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            pend_err_q <= pend_err_d;
        end
    end

    assign busy     = busy_q;
    assign pend_err = pend_err_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port MIPS register file with primary and link write ports,
// same-cycle write-to-read bypass, and a busy scoreboard driving stall.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     stall,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     pend_en,
    input  logic [ADDR_W-1:0]        pend_addr,
    output logic                     pend_err,
    input  logic [ADDR_W-1:0]        dbg_addr,
    output logic [DATA_W-1:0]        dbg_data
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [DATA_W-1:0]   mem_q [NUM_REGS];
    logic [DATA_W-1:0]   mem_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                wr0_eff, wr1_eff;
    logic [ADDR_W-1:0]   idx;
    logic                hit0, hit1, idx_zero;

    // Gating with rst keeps the bypass from leaking write data while in reset.
    assign wr0_eff = wr0_en && !rst && !(ZERO_REG && (wr0_addr == '0));
    assign wr1_eff = wr1_en && !rst && !(ZERO_REG && (wr1_addr == '0));

    regfile_busy_tracker #(
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG)
    ) u_busy (
        .clk      (clk),
        .rst      (rst),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .pend_en  (pend_en),
        .pend_addr(pend_addr),
        .busy     (busy),
        .pend_err (pend_err)
    );

    always_comb begin
        mem_d = mem_q;
        if (wr0_eff) mem_d[wr0_addr] = wr0_data;
        if (wr1_eff) mem_d[wr1_addr] = wr1_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    // Link write has priority over the primary write on the bypass path.
    always_comb begin
        rd_data  = '0;
        rd_busy  = '0;
        idx      = '0;
        hit0     = 1'b0;
        hit1     = 1'b0;
        idx_zero = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            idx      = rd_addr[k*ADDR_W +: ADDR_W];
            hit0     = wr0_eff && (wr0_addr == idx);
            hit1     = wr1_eff && (wr1_addr == idx);
            idx_zero = ZERO_REG && (idx == '0);
            if (idx_zero)
                rd_data[k*DATA_W +: DATA_W] = '0;
            else if (hit1)
                rd_data[k*DATA_W +: DATA_W] = wr1_data;
            else if (hit0)
                rd_data[k*DATA_W +: DATA_W] = wr0_data;
            else
                rd_data[k*DATA_W +: DATA_W] = mem_q[idx];
            rd_busy[k] = busy[idx] && !(hit0 || hit1) && !idx_zero;
        end
    end

    assign stall    = |(rd_en & rd_busy);
    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: an array-level reference model checked
// every negedge, literal spot checks, and a wide/4-port/no-zero-reg instance.
module tb_regfile_scoreboard;
    import regfile_pkg::*;

    logic        clk, rst;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        stall;
    logic        wr0_en, wr1_en, pend_en, pend_err;
    logic [4:0]  wr0_addr, wr1_addr, pend_addr, dbg_addr;
    logic [31:0] wr0_data, wr1_data, dbg_data;

    logic [3:0]   b_rd_en, b_rd_busy;
    logic [15:0]  b_rd_addr;
    logic [255:0] b_rd_data;
    logic         b_stall, b_wr0_en, b_wr1_en, b_pend_en, b_pend_err;
    logic [3:0]   b_wr0_addr, b_wr1_addr, b_pend_addr, b_dbg_addr;
    logic [63:0]  b_wr0_data, b_wr1_data, b_dbg_data;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_regs [32];
    bit          model_busy [32];
    bit          model_err;

    regfile_scoreboard dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .stall(stall),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .pend_en(pend_en), .pend_addr(pend_addr), .pend_err(pend_err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    regfile_scoreboard #(
        .DATA_W(64), .ADDR_W(4), .NUM_RD(MAX_NUM_RD), .ZERO_REG(1'b0)
    ) dut_wide (
        .clk(clk), .rst(rst),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .rd_busy(b_rd_busy), .stall(b_stall),
        .wr0_en(b_wr0_en), .wr0_addr(b_wr0_addr), .wr0_data(b_wr0_data),
        .wr1_en(b_wr1_en), .wr1_addr(b_wr1_addr), .wr1_data(b_wr1_data),
        .pend_en(b_pend_en), .pend_addr(b_pend_addr), .pend_err(b_pend_err),
        .dbg_addr(b_dbg_addr), .dbg_data(b_dbg_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, want %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Value a register will hold after this edge; reads bypass to exactly this.
    function automatic logic [31:0] model_next(input int a);
        if (a == 0) return 32'h0;
        if (wr1_en && int'(wr1_addr) == a) return wr1_data;
        if (wr0_en && int'(wr0_addr) == a) return wr0_data;
        return model_regs[a];
    endfunction

    function automatic bit model_written(input int a);
        return (a != 0) && ((wr0_en && int'(wr0_addr) == a) ||
                            (wr1_en && int'(wr1_addr) == a));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < 32; a++) begin
                model_regs[a] <= 32'h0;
                model_busy[a] <= 1'b0;
            end
            model_err <= 1'b0;
        end else begin
            for (int a = 0; a < 32; a++) begin
                model_regs[a] <= model_next(a);
                if (pend_en && pend_addr != 5'd0 && int'(pend_addr) == a)
                    model_busy[a] <= 1'b1;
                else if (model_written(a))
                    model_busy[a] <= 1'b0;
            end
            if (pend_en && pend_addr != 5'd0 && model_busy[pend_addr] &&
                !model_written(int'(pend_addr)))
                model_err <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            checkOutput("rst_rd_data", {32'h0, rd_data}, 64'h0);
            checkOutput("rst_rd_busy", {62'h0, rd_busy}, 64'h0);
            checkOutput("rst_stall", {63'h0, stall}, 64'h0);
            checkOutput("rst_pend_err", {63'h0, pend_err}, 64'h0);
            checkOutput("rst_dbg", {32'h0, dbg_data}, 64'h0);
        end else begin
            logic exp_stall;
            exp_stall = 1'b0;
            for (int k = 0; k < 2; k++) begin
                int  a;
                bit  eb;
                a  = int'(rd_addr[k*5 +: 5]);
                eb = (a != 0) && model_busy[a] && !model_written(a);
                checkOutput("model_rd_data", {32'h0, rd_data[k*32 +: 32]},
                            {32'h0, model_next(a)});
                checkOutput("model_rd_busy", {63'h0, rd_busy[k]}, {63'h0, eb});
                exp_stall = exp_stall | (rd_en[k] & eb);
            end
            checkOutput("model_stall", {63'h0, stall}, {63'h0, exp_stall});
            checkOutput("model_pend_err", {63'h0, pend_err}, {63'h0, model_err});
            checkOutput("model_dbg", {32'h0, dbg_data}, {32'h0, model_regs[dbg_addr]});
        end
    end

    task automatic applyStimulus(input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
                                 input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
                                 input logic pe, input logic [4:0] pa, input logic [1:0] re,
                                 input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] da);
        @(posedge clk);
        #1;
        wr0_en = w0e; wr0_addr = w0a; wr0_data = w0d;
        wr1_en = w1e; wr1_addr = w1a; wr1_data = w1d;
        pend_en = pe; pend_addr = pa;
        rd_en = re; rd_addr = {r1, r0}; dbg_addr = da;
        #1;
    endtask

    task automatic stepWide(input logic w0e, input logic [3:0] w0a, input logic [63:0] w0d,
                            input logic w1e, input logic [3:0] w1a, input logic [63:0] w1d,
                            input logic pe, input logic [3:0] pa, input logic [3:0] re,
                            input logic [15:0] ra, input logic [3:0] da);
        @(posedge clk);
        #1;
        b_wr0_en = w0e; b_wr0_addr = w0a; b_wr0_data = w0d;
        b_wr1_en = w1e; b_wr1_addr = w1a; b_wr1_data = w1d;
        b_pend_en = pe; b_pend_addr = pa;
        b_rd_en = re; b_rd_addr = ra; b_dbg_addr = da;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        rd_en = '0; rd_addr = '0; wr0_en = 0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 0; wr1_addr = '0; wr1_data = '0; pend_en = 0; pend_addr = '0; dbg_addr = '0;
        b_rd_en = '0; b_rd_addr = '0; b_wr0_en = 0; b_wr0_addr = '0; b_wr0_data = '0;
        b_wr1_en = 0; b_wr1_addr = '0; b_wr1_data = '0; b_pend_en = 0; b_pend_addr = '0;
        b_dbg_addr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Bypass: new value visible on the read port, debug tap still old.
        applyStimulus(1, 5'd8, 32'h12345678, 0, 5'd0, 0, 0, 5'd0, 2'b00, 5'd8, 5'd0, 5'd8);
        checkOutput("bypass_rd0", {32'h0, rd_data[31:0]}, 64'h12345678);
        checkOutput("bypass_dbg_old", {32'h0, dbg_data}, 64'h0);
        applyStimulus(0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 2'b00, 5'd8, 5'd0, 5'd8);
        checkOutput("bypass_dbg_new", {32'h0, dbg_data}, 64'h12345678);

        // Same-address conflict (link wins) and writes to r0 ignored.
        applyStimulus(1, 5'd31, 32'h11, 1, RA[4:0], 32'h400008, 0, 5'd0, 2'b00, 5'd31, 5'd0, 5'd0);
        checkOutput("conflict_bypass", {32'h0, rd_data[31:0]}, 64'h400008);
        applyStimulus(1, 5'd0, 32'hFF, 0, 5'd0, 0, 0, 5'd0, 2'b00, 5'd31, 5'd0, RA[4:0]);
        checkOutput("zero_reg_read", {32'h0, rd_data[63:32]}, 64'h0);
        checkOutput("conflict_ra", {32'h0, dbg_data}, 64'h400008);
        applyStimulus(1, V0[4:0], 32'h0A, 1, A0[4:0], 32'h4, 0, 5'd0, 2'b00, V0[4:0], A0[4:0], 5'd0);
        checkOutput("zero_reg_dbg", {32'h0, dbg_data}, 64'h0);
        applyStimulus(0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 2'b00, V0[4:0], A0[4:0], A0[4:0]);
        checkOutput("dual_write_v0", {32'h0, rd_data[31:0]}, 64'h0A);
        checkOutput("dual_write_a0", {32'h0, dbg_data}, 64'h4);

        // Scoreboard: pend, stall, completing write unblocks via bypass.
        applyStimulus(0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd9, 2'b01, 5'd9, 5'd0, 5'd9);
        checkOutput("pend_not_yet_busy", {62'h0, rd_busy}, 64'h0);
        applyStimulus(0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 2'b01, 5'd9, 5'd0, 5'd9);
        checkOutput("busy_rd0", {62'h0, rd_busy}, 64'h1);
        checkOutput("busy_stall", {63'h0, stall}, 64'h1);
        applyStimulus(1, 5'd9, 32'hAB, 0, 5'd0, 0, 0, 5'd0, 2'b01, 5'd9, 5'd0, 5'd9);
        checkOutput("complete_data", {32'h0, rd_data[31:0]}, 64'hAB);
        checkOutput("complete_stall", {63'h0, stall}, 64'h0);
        applyStimulus(0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 2'b01, 5'd9, 5'd0, 5'd9);
        checkOutput("busy_cleared", {62'h0, rd_busy}, 64'h0);

        // Set wins over clear; a second pend on a busy register is an error.
        applyStimulus(0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd9, 2'b00, 5'd9, 5'd0, 5'd9);
        applyStimulus(1, 5'd9, 32'h1, 0, 5'd0, 0, 1, 5'd9, 2'b01, 5'd9, 5'd0, 5'd9);
        checkOutput("setwin_bypass", {32'h0, rd_data[31:0]}, 64'h1);
        applyStimulus(0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd9, 2'b01, 5'd9, 5'd0, 5'd9);
        checkOutput("setwin_still_busy", {63'h0, stall}, 64'h1);
        checkOutput("setwin_no_err", {63'h0, pend_err}, 64'h0);
        checkOutput("setwin_data", {32'h0, dbg_data}, 64'h1);
        applyStimulus(1, 5'd9, 32'h2, 0, 5'd0, 0, 0, 5'd0, 2'b00, 5'd9, 5'd0, 5'd9);
        checkOutput("pend_err_set", {63'h0, pend_err}, 64'h1);
        applyStimulus(0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 2'b00, 5'd9, 5'd0, 5'd9);
        checkOutput("pend_err_sticky", {63'h0, pend_err}, 64'h1);

        // Asynchronous reset between edges clears everything at once.
        applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 0, 0, 5'd0, 2'b00, 5'd5, 5'd6, 5'd5);
        applyStimulus(0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd6, 2'b11, 5'd5, 5'd6, 5'd5);
        checkOutput("pre_rst_data", {32'h0, rd_data[31:0]}, 64'hDEADBEEF);
        applyStimulus(0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 2'b11, 5'd5, 5'd6, 5'd5);
        checkOutput("pre_rst_stall", {63'h0, stall}, 64'h1);
        #1 rst = 1'b1;
        #1;
        checkOutput("async_rst_data", {32'h0, rd_data[31:0]}, 64'h0);
        checkOutput("async_rst_busy", {62'h0, rd_busy}, 64'h0);
        checkOutput("async_rst_err", {63'h0, pend_err}, 64'h0);
        @(negedge clk);
        #1 rst = 1'b0;
        applyStimulus(0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 2'b00, 5'd0, 5'd0, 5'd0);

        // Wide instance: r0 is an ordinary register and four independent ports.
        stepWide(1, 4'd0, 64'h5, 1, 4'd1, 64'hAAAA_BBBB_CCCC_0001, 0, 4'd0, 4'b0000,
                 {4'd3, 4'd2, 4'd1, 4'd0}, 4'd0);
        checkOutput("wide_r0_bypass", b_rd_data[63:0], 64'h5);
        stepWide(1, 4'd2, 64'h0123_4567_89AB_CDEF, 1, 4'd3, 64'hFEDC_BA98_7654_3210, 0, 4'd0,
                 4'b0000, {4'd3, 4'd2, 4'd1, 4'd0}, 4'd0);
        stepWide(0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 4'b0000, {4'd3, 4'd2, 4'd1, 4'd0}, 4'd0);
        checkOutput("wide_p0", b_rd_data[63:0], 64'h5);
        checkOutput("wide_p1", b_rd_data[127:64], 64'hAAAA_BBBB_CCCC_0001);
        checkOutput("wide_p2", b_rd_data[191:128], 64'h0123_4567_89AB_CDEF);
        checkOutput("wide_p3", b_rd_data[255:192], 64'hFEDC_BA98_7654_3210);
        checkOutput("wide_dbg_r0", b_dbg_data, 64'h5);
        stepWide(0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 4'b0000, {4'd0, 4'd1, 4'd2, 4'd3}, 4'd0);
        checkOutput("wide_rev_p0", b_rd_data[63:0], 64'hFEDC_BA98_7654_3210);
        checkOutput("wide_rev_p3", b_rd_data[255:192], 64'h5);
        stepWide(0, 4'd0, 0, 0, 4'd0, 0, 1, 4'd0, 4'b0001, {4'd0, 4'd0, 4'd0, 4'd0}, 4'd0);
        checkOutput("wide_pend_r0_pre", {60'h0, b_rd_busy}, 64'h0);
        stepWide(0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 4'b0001, {4'd0, 4'd0, 4'd0, 4'd0}, 4'd0);
        checkOutput("wide_pend_r0_busy", {60'h0, b_rd_busy}, 64'hF);
        checkOutput("wide_pend_r0_stall", {63'h0, b_stall}, 64'h1);

        repeat (2) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
